// File: rtl/spike_packet_dispatcher_if.sv
// Front-end handshakes (header, spike packets) and the Wishbone master bus of
// the spike packet dispatcher, bundled as one port group.
interface spike_packet_dispatcher_if;
  // image header handshake
  logic        hdr_valid_i;
  logic        hdr_ready_o;
  logic [7:0]  hdr_num_packets_i;
  // spike packet stream
  logic        pkt_valid_i;
  logic        pkt_ready_o;
  logic [7:0]  pkt_axon_i;
  // Wishbone master towards the neuron core
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;

  // dispatcher side
  modport master (
    input  hdr_valid_i, hdr_num_packets_i, pkt_valid_i, pkt_axon_i, wbm_ack_i,
    output hdr_ready_o, pkt_ready_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  // producer / neuron-core side
  modport slave (
    output hdr_valid_i, hdr_num_packets_i, pkt_valid_i, pkt_axon_i, wbm_ack_i,
    input  hdr_ready_o, pkt_ready_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/spike_packet_dispatcher.sv
// Spike packet dispatcher: buffers axon-index packets in a FIFO and, per image
// header, issues one image-start event write followed by one synapse-row write
// per packet to the neuron core over Wishbone, with an ack timeout.
module spike_packet_dispatcher #(
  parameter logic [31:0] EVENT_ADDR      = 32'h3000_C000,
  parameter logic [31:0] PKT_BASE        = 32'h3000_0000,
  parameter int unsigned PKT_STRIDE_LOG2 = 6,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  spike_packet_dispatcher_if.master bus,
  output logic                      busy_o,
  output logic                      image_done_o,
  output logic                      timeout_err_o,
  output logic [7:0]                packets_sent_o
);

  localparam int unsigned AW       = FIFO_DEPTH_LOG2;
  localparam int unsigned DEPTH    = 2 ** AW;
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR_WR   = 3'd1,
    S_PKT_WAIT = 3'd2,
    S_PKT_WR   = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        flush;
  logic [7:0]  head;

  logic [7:0]  num;
  logic [7:0]  tmo_cnt;
  logic        hdr_acc;
  logic        xfer_ack;
  logic        tmo_hit;
  logic        stb_rise;
  logic [7:0]  sent_inc;
  logic        last_pkt;

  // next values of the registered outputs
  logic        cyc_d;
  logic        stb_d;
  logic        we_d;
  logic [3:0]  sel_d;
  logic [31:0] adr_d;
  logic [31:0] dat_d;
  logic        busy_d;
  logic        done_d;
  logic        err_d;
  logic [7:0]  sent_d;
  logic [7:0]  num_d;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];

  assign bus.hdr_ready_o = (state == S_IDLE);
  assign bus.pkt_ready_o = !fifo_full;

  // stb is only ever high in HDR_WR / PKT_WR, so a stray ack is ignored
  assign hdr_acc  = bus.hdr_valid_i && (state == S_IDLE);
  assign xfer_ack = bus.wbm_stb_o && bus.wbm_ack_i;
  assign tmo_hit  = bus.wbm_stb_o && !bus.wbm_ack_i && (tmo_cnt == TMO_LAST);
  assign stb_rise = stb_d && !bus.wbm_stb_o;

  // a timeout discards everything buffered, including a same-cycle push
  assign flush = tmo_hit;
  assign push  = bus.pkt_valid_i && !fifo_full && !flush;
  assign pop   = (state == S_PKT_WR) && xfer_ack;

  assign sent_inc = packets_sent_o + 8'd1;
  assign last_pkt = (sent_inc == num);

  // packet storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= bus.pkt_axon_i;
    end
  end

  // FIFO pointers; a full FIFO refuses a push even when a pop coincides
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // ack-wait counter: cleared as stb rises, counts unacked strobe cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (stb_rise) begin
      tmo_cnt <= '0;
    end else if (bus.wbm_stb_o && !bus.wbm_ack_i) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (hdr_acc) state_nx = S_HDR_WR;
      end
      S_HDR_WR: begin
        if (xfer_ack)     state_nx = (num == 8'd0) ? S_DONE : S_PKT_WAIT;
        else if (tmo_hit) state_nx = S_IDLE;
      end
      S_PKT_WAIT: begin
        if (!fifo_empty) state_nx = S_PKT_WR;
      end
      S_PKT_WR: begin
        if (xfer_ack)     state_nx = last_pkt ? S_DONE : S_PKT_WAIT;
        else if (tmo_hit) state_nx = S_IDLE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // FSM output logic: next values for the bus and status registers
  always_comb begin
    cyc_d  = bus.wbm_cyc_o;
    stb_d  = bus.wbm_stb_o;
    we_d   = bus.wbm_we_o;
    sel_d  = bus.wbm_sel_o;
    adr_d  = bus.wbm_adr_o;
    dat_d  = bus.wbm_dat_o;
    busy_d = (state_nx != S_IDLE);
    done_d = (state_nx == S_DONE);
    err_d  = timeout_err_o;
    sent_d = packets_sent_o;
    num_d  = num;
    unique case (state)
      S_IDLE: begin
        if (hdr_acc) begin
          num_d  = bus.hdr_num_packets_i;
          sent_d = 8'd0;
          err_d  = 1'b0;
          cyc_d  = 1'b1;
          stb_d  = 1'b1;
          we_d   = 1'b1;
          sel_d  = 4'hF;
          adr_d  = EVENT_ADDR;
          dat_d  = {24'b0, bus.hdr_num_packets_i};
        end
      end
      S_HDR_WR, S_PKT_WR: begin
        if (xfer_ack || tmo_hit) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          sel_d = 4'h0;
        end
        if (tmo_hit) err_d = 1'b1;
        if (xfer_ack && (state == S_PKT_WR)) sent_d = sent_inc;
      end
      S_PKT_WAIT: begin
        if (!fifo_empty) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
          we_d  = 1'b1;
          sel_d = 4'hF;
          adr_d = PKT_BASE + (32'(head) << PKT_STRIDE_LOG2);
          dat_d = 32'(head);
        end
      end
      default: begin
      end
    endcase
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wbm_cyc_o  <= 1'b0;
      bus.wbm_stb_o  <= 1'b0;
      bus.wbm_we_o   <= 1'b0;
      bus.wbm_sel_o  <= 4'h0;
      bus.wbm_adr_o  <= 32'h0;
      bus.wbm_dat_o  <= 32'h0;
      busy_o         <= 1'b0;
      image_done_o   <= 1'b0;
      timeout_err_o  <= 1'b0;
      packets_sent_o <= 8'd0;
      num            <= 8'd0;
    end else begin
      bus.wbm_cyc_o  <= cyc_d;
      bus.wbm_stb_o  <= stb_d;
      bus.wbm_we_o   <= we_d;
      bus.wbm_sel_o  <= sel_d;
      bus.wbm_adr_o  <= adr_d;
      bus.wbm_dat_o  <= dat_d;
      busy_o         <= busy_d;
      image_done_o   <= done_d;
      timeout_err_o  <= err_d;
      packets_sent_o <= sent_d;
      num            <= num_d;
    end
  end

endmodule

// File: doc/spike_packet_dispatcher.md
Name: spike_packet_dispatcher

Overview:
- Wishbone master that feeds the 256x256 neuron core's slave port directly upstream of it.
- Accepts one image header (packet count) and a stream of axon-index spike packets, and buffers packets in a FIFO.
- Issues the core's bus writes in order: one image-start event write to the spike-event region, then one write per packet to the synapse region.
- Reports image completion, progress and bus timeout.

Parameters:
- EVENT_ADDR, 32'h3000C000, target address of the image-start event write
- PKT_BASE, 32'h30000000, base address of per-packet writes
- PKT_STRIDE_LOG2, 6, log2 of the byte stride between axon rows; packet address = PKT_BASE + (axon << PKT_STRIDE_LOG2)
- FIFO_DEPTH_LOG2, 4, packet FIFO depth = 2^FIFO_DEPTH_LOG2 (16)
- TIMEOUT_CYCLES, 255, maximum wait for ack after stb asserts; range 1..255

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- hdr_valid_i  in  1  image header valid
- hdr_ready_o  out  1  header accepted when hdr_valid_i & hdr_ready_o
- hdr_num_packets_i  in  8  number of packets in the image (0..255)
- pkt_valid_i  in  1  spike packet valid
- pkt_ready_o  out  1  high when the FIFO is not full
- pkt_axon_i  in  8  axon index of the spike packet
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  always 1 during a transfer
- wbm_sel_o  out  4  4'hF during a transfer, else 0
- wbm_adr_o  out  32  transfer address
- wbm_dat_o  out  32  transfer data
- wbm_ack_i  in  1  slave acknowledge
- busy_o  out  1  high when state != IDLE
- image_done_o  out  1  one-cycle pulse when an image completes normally
- timeout_err_o  out  1  sticky flag; set on bus timeout, cleared on the next header accept
- packets_sent_o  out  8  packets acknowledged in the current image

Behaviour:
- Reset values: all wbm_* outputs 0; busy_o 0; image_done_o 0; timeout_err_o 0; packets_sent_o 0; FIFO empty; state IDLE; pkt_ready_o 1; hdr_ready_o 1.
- All outputs are registered except the ready signals:
  - hdr_ready_o = (state == IDLE)
  - pkt_ready_o = !fifo_full
- FIFO push: pkt_valid_i & pkt_ready_o. Push is independent of state, so packets may arrive before their header.
- FIFO pop: only on wbm_ack_i in PKT_WR. Push and pop in the same cycle are legal and the count is unchanged. No full bypass: a pop in the same cycle does not make a full FIFO accept a push.
- States: IDLE, HDR_WR, PKT_WAIT, PKT_WR, DONE.
- IDLE:
  - On header accept, latch num <= hdr_num_packets_i, clear packets_sent_o and timeout_err_o, go to HDR_WR.
  - wbm_cyc_o/wbm_stb_o rise in the cycle after the accept edge.
- HDR_WR:
  - Drive adr = EVENT_ADDR, dat = {24'b0, num}.
  - On ack, deassert cyc/stb at the next edge.
  - If num == 0, go to DONE; else go to PKT_WAIT.
- PKT_WAIT: when the FIFO is non-empty, go to PKT_WR and raise cyc/stb at the next edge, with adr/dat taken from the FIFO head.
- PKT_WR:
  - Drive adr = PKT_BASE + ({24'b0, head} << PKT_STRIDE_LOG2), dat = {24'b0, head}.
  - On ack: pop, increment packets_sent_o, drop cyc/stb.
  - If packets_sent_o + 1 == num, go to DONE; else go to PKT_WAIT.
- Transfer spacing: at least one idle cycle (cyc = 0) between consecutive transfers.
- Transfer hold: adr/dat/sel/we stay stable while stb is high.
- DONE: pulse image_done_o for one cycle, return to IDLE. A new header may be accepted in the following cycle.
- Timeout:
  - An 8-bit counter clears when stb rises and increments each cycle that stb is high without ack.
  - When the counter reaches TIMEOUT_CYCLES with no ack: drop cyc/stb, set timeout_err_o, flush the FIFO, go to IDLE.
  - No image_done_o pulse on timeout. packets_sent_o holds its value.
- An ack arriving in the same cycle the counter would expire counts as success.
- wbm_ack_i outside a transfer is ignored.
- Reset mid-transfer: cyc/stb go to 0 at the reset edge; FIFO contents are lost.

Test Plan:
- Header num=3, axons 5,17,255 pushed beforehand → writes in order: 0x3000C000 dat 3; 0x30000140 dat 5; 0x30000440 dat 17; 0x30003FC0 dat 255; image_done_o pulses once; packets_sent_o=3.
- Header num=0 → single write to 0x3000C000 dat 0, then image_done_o; no packet writes.
- Push 17 packets back-to-back with no header → 16 accepted, pkt_ready_o low on the 17th. Header num=16 with ack delayed 2 cycles → 17 transfers, each with ≥1 idle cycle between them.
- Slave never acks the 2nd packet, TIMEOUT_CYCLES=8 → stb drops after 8 cycles, timeout_err_o=1, packets_sent_o=1, FIFO empty, hdr_ready_o=1. The next header accept clears timeout_err_o.
- Assert rst while stb is high mid-image → all outputs take their reset values the next cycle; a subsequent image num=1 completes normally.
- Push while full with simultaneous pop-ack → push refused that cycle and accepted the next; order is preserved.
